// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and
// default PC / instruction widths.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_W_DEFAULT   = 2;
  localparam int unsigned INST_W_DEFAULT = 32;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush. The head read holds the last presented
// word while empty, so downstream data does not change when out_valid drops.
module fetch_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      // Capture the head whenever it disappears (pop or flush) so dout holds.
      if ((do_pop || flush) && !empty) begin
        last_q <= mem[rd_ptr];
      end
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (do_pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (do_push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (do_push && !do_pop) begin
          count_q <= count_q + CW'(1);
        end else if (do_pop && !do_push) begin
          count_q <= count_q - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IDLE/RUN/DRAIN control, prefetch FIFO.
// Optional FETCH_PERF_EN adds saturating fetch_count / stall_count outputs.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEFAULT,
  parameter int unsigned INST_W = INST_W_DEFAULT,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              im_cs,
  output logic [PC_W-1:0]   im_addr,
  input  logic [INST_W-1:0] im_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
`ifdef FETCH_PERF_EN
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count,
`endif
  output logic [PC_W-1:0]   out_pc
);

  localparam int unsigned FW = INST_W + PC_W;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [PC_W-1:0]  pc_q;
  logic             fetch;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             empty_after_pop;
  logic [FW-1:0]    fifo_dout;

  assign pop             = out_valid && out_ready;
  assign empty_after_pop = fifo_empty || ((fifo_count == CW'(1)) && pop);

  always_comb begin
    state_d = state_q;
    fetch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = (redirect_valid || empty_after_pop) ? IDLE : DRAIN;
        end else begin
          fetch = (!fifo_full || pop) && !redirect_valid;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          state_d = IDLE;
        end else if (en) begin
          state_d = RUN;
        end else if (empty_after_pop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset_n so no memory access is issued during a reset cycle.
  assign im_cs   = fetch && reset_n;
  assign im_addr = pc_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (fetch) begin
        pc_q <= pc_q + PC_W'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (im_cs),
    .pop     (pop),
    .flush   (redirect_valid),
    .din     ({im_data, pc_q}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_inst  = fifo_dout[FW-1:PC_W];
  assign out_pc    = fifo_dout[PC_W-1:0];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (im_cs && (fetch_count != '1)) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if ((state_q == RUN) && out_valid && !out_ready && (stall_count != '1)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (PC_W=2, DEPTH=2).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        redirect_valid;
  logic [1:0]  redirect_pc;
  logic        im_cs;
  logic [1:0]  im_addr;
  logic [31:0] im_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [1:0]  out_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  logic [31:0] mem [4];
  int tests;
  int fails;

  assign im_data = mem[im_addr];

  fetch_unit #(
    .PC_W   (2),
    .INST_W (32),
    .DEPTH  (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_cs          (im_cs),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
`ifdef FETCH_PERF_EN
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
`endif
    .out_pc         (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    en             = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 2'd0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    tests++;
    if (out_inst !== 32'h0 || out_pc !== 2'd0) begin
      fails++; $display("FAIL reset_outs got=%h/%0d exp=0/0", out_inst, out_pc);
    end
    tests++;
    if (im_cs !== 1'b0 || im_addr !== 2'd0) begin
      fails++; $display("FAIL reset_im got=%b/%0d exp=0/0", im_cs, im_addr);
    end
    tests++;
    if (dut.state_q !== IDLE) begin
      fails++; $display("FAIL reset_state got=%0d exp=0", dut.state_q);
    end
  endtask

  task automatic test_stream();
    logic [1:0] ep;
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    #1;
    tests++;
    if (im_cs !== 1'b0) begin
      fails++; $display("FAIL stream_idle_cs got=%b exp=0", im_cs);
    end
    tick(); #1;
    tests++;
    if (out_valid !== 1'b0 || im_cs !== 1'b1 || im_addr !== 2'd0) begin
      fails++; $display("FAIL stream_run got v=%b cs=%b a=%0d exp v=0 cs=1 a=0", out_valid, im_cs, im_addr);
    end
    tick(); #1;
    tests++;
    if (out_valid !== 1'b1 || out_inst !== 32'hA0000000 || out_pc !== 2'd0) begin
      fails++; $display("FAIL stream_first got v=%b %h/%0d exp 1 A0000000/0", out_valid, out_inst, out_pc);
    end
    for (int i = 1; i <= 4; i++) begin
      tick(); #1;
      ep = 2'(i % 4);
      tests++;
      if (out_valid !== 1'b1 || out_inst !== mem[ep] || out_pc !== ep) begin
        fails++; $display("FAIL stream_word%0d got v=%b %h/%0d exp 1 %h/%0d", i, out_valid, out_inst, out_pc, mem[ep], ep);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    #1;
    tests++;
    if (im_cs !== 1'b1 || out_inst !== 32'hA0000000) begin
      fails++; $display("FAIL bp_second_push got cs=%b %h exp 1 A0000000", im_cs, out_inst);
    end
    tick(); #1;
    tests++;
    if (im_cs !== 1'b0 || im_addr !== 2'd2) begin
      fails++; $display("FAIL bp_full got cs=%b a=%0d exp 0/2", im_cs, im_addr);
    end
    tick(); tick(); tick(); #1;
    tests++;
    if (im_cs !== 1'b0 || im_addr !== 2'd2 || out_inst !== 32'hA0000000 || out_pc !== 2'd0) begin
      fails++; $display("FAIL bp_hold got cs=%b a=%0d %h/%0d exp 0/2 A0000000/0", im_cs, im_addr, out_inst, out_pc);
    end
    tick();
    out_ready = 1'b1;
    #1;
    tests++;
    if (im_cs !== 1'b1 || out_inst !== 32'hA0000000 || out_pc !== 2'd0) begin
      fails++; $display("FAIL bp_release got cs=%b %h/%0d exp 1 A0000000/0", im_cs, out_inst, out_pc);
    end
    tick(); #1;
    tests++;
    if (out_valid !== 1'b1 || out_inst !== 32'hA1111111 || out_pc !== 2'd1) begin
      fails++; $display("FAIL bp_next1 got v=%b %h/%0d exp 1 A1111111/1", out_valid, out_inst, out_pc);
    end
    tick(); #1;
    tests++;
    if (out_valid !== 1'b1 || out_inst !== 32'hA2222222 || out_pc !== 2'd2) begin
      fails++; $display("FAIL bp_next2 got v=%b %h/%0d exp 1 A2222222/2", out_valid, out_inst, out_pc);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 2'd3;
    #1;
    tests++;
    if (im_cs !== 1'b0) begin
      fails++; $display("FAIL redir_cs got=%b exp=0", im_cs);
    end
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || im_cs !== 1'b1 || im_addr !== 2'd3 || out_inst !== 32'hA0000000) begin
      fails++; $display("FAIL redir_gap got v=%b cs=%b a=%0d %h exp 0 1 3 A0000000", out_valid, im_cs, im_addr, out_inst);
    end
    tick(); #1;
    tests++;
    if (out_valid !== 1'b1 || out_inst !== 32'hA3333333 || out_pc !== 2'd3) begin
      fails++; $display("FAIL redir_target got v=%b %h/%0d exp 1 A3333333/3", out_valid, out_inst, out_pc);
    end
    tick(); #1;
    tests++;
    if (out_valid !== 1'b1 || out_inst !== 32'hA0000000 || out_pc !== 2'd0) begin
      fails++; $display("FAIL redir_follow got v=%b %h/%0d exp 1 A0000000/0", out_valid, out_inst, out_pc);
    end
  endtask

  task automatic test_drain();
    do_reset();
    en = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b0; out_ready = 1'b1;
    #1;
    tests++;
    if (im_cs !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'hA0000000) begin
      fails++; $display("FAIL drain_first got cs=%b v=%b %h exp 0 1 A0000000", im_cs, out_valid, out_inst);
    end
    tick(); #1;
    tests++;
    if (im_cs !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'hA1111111 || out_pc !== 2'd1) begin
      fails++; $display("FAIL drain_second got cs=%b v=%b %h/%0d exp 0 1 A1111111/1", im_cs, out_valid, out_inst, out_pc);
    end
    tick(); #1;
    tests++;
    if (out_valid !== 1'b0 || im_cs !== 1'b0 || dut.state_q !== IDLE) begin
      fails++; $display("FAIL drain_idle got v=%b cs=%b st=%0d exp 0 0 0", out_valid, im_cs, dut.state_q);
    end
    tick(); #1;
    tests++;
    if (im_addr !== 2'd2 || out_inst !== 32'hA1111111) begin
      fails++; $display("FAIL drain_pc_hold got a=%0d %h exp 2 A1111111", im_addr, out_inst);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    tests++;
    if (im_cs !== 1'b0) begin
      fails++; $display("FAIL midrst_cs got=%b exp=0", im_cs);
    end
    tick();
    reset_n = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pc !== 2'd0 || im_addr !== 2'd0 || im_cs !== 1'b0) begin
      fails++; $display("FAIL midrst_state got v=%b %h/%0d a=%0d cs=%b exp 0 0/0 0 0", out_valid, out_inst, out_pc, im_addr, im_cs);
    end
    tick();
    tick(); #1;
    tests++;
    if (out_valid !== 1'b1 || out_inst !== 32'hA0000000 || out_pc !== 2'd0) begin
      fails++; $display("FAIL midrst_restart got v=%b %h/%0d exp 1 A0000000/0", out_valid, out_inst, out_pc);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    en = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    #1;
    tests++;
    if (fetch_count !== 16'd6 || stall_count !== 16'd3) begin
      fails++; $display("FAIL perf_counts got f=%0d s=%0d exp 6/3", fetch_count, stall_count);
    end
  endtask
`endif

  initial begin
    mem[0] = 32'hA0000000;
    mem[1] = 32'hA1111111;
    mem[2] = 32'hA2222222;
    mem[3] = 32'hA3333333;
    tests = 0;
    fails = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_drain();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
